// File: rtl/gpr_file_mp.sv
// Parametrised multi-port GPR file with hardware clear sequencer and pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining GPR_BYPASS_EN.
module gpr_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Clr,
    output logic              Ready,
    input  logic              GPRWr,
    input  logic [ADDR_W-1:0] W_Reg,
    input  logic [DATA_W-1:0] W_data,
    input  logic [ADDR_W-1:0] R_Reg1,
    input  logic [ADDR_W-1:0] R_Reg2,
    output logic [DATA_W-1:0] R_data1,
    output logic [DATA_W-1:0] R_data2,
    input  logic              RsvWr,
    input  logic [ADDR_W-1:0] RsvReg,
    output logic              R_busy1,
    output logic              R_busy2
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic                ready_q;
    logic [DATA_W-1:0]   regs [DEPTH];

    logic                arr_we;
    logic [ADDR_W-1:0]   arr_addr;
    logic [DATA_W-1:0]   arr_data;
    logic                wr_ok_c;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_ok_c = (state_q == RUN) && GPRWr && !is_zero(W_Reg);
    assign Ready   = ready_q;

    // State, clear counter and scoreboard registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= (state_d == RUN);
        end
    end

    // Next-state, array write port selection and scoreboard update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        arr_we   = 1'b0;
        arr_addr = W_Reg;
        arr_data = W_data;
        case (state_q)
            CLEAR: begin
                arr_we   = 1'b1;
                arr_addr = cnt_q;
                arr_data = '0;
                cnt_d    = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                arr_we = wr_ok_c;
                if (wr_ok_c) begin
                    busy_d[W_Reg] = 1'b0;
                end
                // Reservation applied after the write so it wins on a same-address collision
                if (RsvWr && !is_zero(RsvReg)) begin
                    busy_d[RsvReg] = 1'b1;
                end
                if (Clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Storage array; contents are defined by the clear sequencer, not by reset
    always_ff @(posedge CLK) begin
        if (arr_we) begin
            regs[arr_addr] <= arr_data;
        end
    end

    // Combinational read ports
    always_comb begin
        R_data1 = '0;
        R_data2 = '0;
        R_busy1 = 1'b0;
        R_busy2 = 1'b0;
        if (state_q == RUN) begin
            if (!is_zero(R_Reg1)) begin
                R_data1 = regs[R_Reg1];
                R_busy1 = busy_q[R_Reg1];
            end
            if (!is_zero(R_Reg2)) begin
                R_data2 = regs[R_Reg2];
                R_busy2 = busy_q[R_Reg2];
            end
`ifdef GPR_BYPASS_EN
            if (wr_ok_c && (R_Reg1 == W_Reg)) begin
                R_data1 = W_data;
                R_busy1 = 1'b0;
            end
            if (wr_ok_c && (R_Reg2 == W_Reg)) begin
                R_data2 = W_data;
                R_busy2 = 1'b0;
            end
`endif
        end
    end

endmodule
